// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM state encoding, default line
// configuration used by both the TX and RX paths, and a parity helper.
// Optional build macro: UART_RX_PARITY_EN adds the PARITY receive state.
package uart_pkg;

  localparam int UART_CLKS_PER_BIT = 868;
  localparam int UART_DATA_BITS    = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } uart_rx_state_t;

  // Even parity of a byte: the bit that makes the total count of ones even.
  function automatic logic even_parity8(input logic [7:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line plus a
// high-to-low edge detector. All flops reset to the idle (high) level so
// that leaving reset never looks like a start edge.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rx_in,
  output logic rx_s,
  output logic fall
);

  logic meta_r;
  logic rx_prev;

  // Resynchronise rx_in and keep one cycle of history for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r  <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      meta_r  <= rx_in;
      rx_s    <= meta_r;
      rx_prev <= rx_s;
    end
  end

  assign fall = rx_prev & ~rx_s;

endmodule

// File: rtl/uart_rx_core.sv
// UART receive engine: recovers frames from the synchronised serial line
// with a fixed clocks-per-bit divider, samples each bit at its midpoint and
// hands completed bytes to the RX FIFO over a valid/ready interface.
// Optional build macro: UART_RX_PARITY_EN (even parity bit after the data;
// without it the frame is 8N1 and parity_err is constant 0).
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int DATA_BITS    = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 parity_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_BITS + 1);

  // Start is checked half a bit in; every later sample is one full bit on.
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] BIT_ONE   = BIT_W'(1);

  logic                 rx_s;
  logic                 fall_s;
  uart_rx_state_t       state_r;
  logic [CNT_W-1:0]     baud_cnt_r;
  logic [BIT_W-1:0]     bit_cnt_r;
  logic [DATA_BITS-1:0] shift_r;
`ifdef UART_RX_PARITY_EN
  logic                 parity_bad_r;
`endif

  uart_rx_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .rx_in (rx_in),
    .rx_s  (rx_s),
    .fall  (fall_s)
  );

  // Frame FSM with bit timing, shifting, delivery handshake and error pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      baud_cnt_r <= {CNT_W{1'b0}};
      bit_cnt_r  <= {BIT_W{1'b0}};
      shift_r    <= {DATA_BITS{1'b0}};
      rx_data    <= {DATA_BITS{1'b0}};
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err   <= 1'b0;
      parity_bad_r <= 1'b0;
`endif
    end else begin
      // Error flags are single-cycle pulses.
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      // A consumed byte frees the slot; a load below on the same edge wins.
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      case (state_r)
        IDLE: begin
          baud_cnt_r <= {CNT_W{1'b0}};
          bit_cnt_r  <= {BIT_W{1'b0}};
          if (fall_s) begin
            state_r <= START;
          end
        end

        START: begin
          if (baud_cnt_r == HALF_LAST) begin
            baud_cnt_r <= {CNT_W{1'b0}};
            bit_cnt_r  <= {BIT_W{1'b0}};
            // A line already back high at mid-start was a glitch.
            state_r    <= rx_s ? IDLE : DATA;
          end else begin
            baud_cnt_r <= baud_cnt_r + CNT_ONE;
          end
        end

        DATA: begin
          if (baud_cnt_r == FULL_LAST) begin
            baud_cnt_r <= {CNT_W{1'b0}};
            shift_r    <= {rx_s, shift_r[DATA_BITS-1:1]};
            if (bit_cnt_r == BIT_LAST) begin
              bit_cnt_r <= {BIT_W{1'b0}};
`ifdef UART_RX_PARITY_EN
              state_r   <= PARITY;
`else
              state_r   <= STOP;
`endif
            end else begin
              bit_cnt_r <= bit_cnt_r + BIT_ONE;
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + CNT_ONE;
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (baud_cnt_r == FULL_LAST) begin
            baud_cnt_r   <= {CNT_W{1'b0}};
            parity_bad_r <= rx_s ^ even_parity8(8'(shift_r));
            state_r      <= STOP;
          end else begin
            baud_cnt_r <= baud_cnt_r + CNT_ONE;
          end
        end
`endif

        STOP: begin
          if (baud_cnt_r == FULL_LAST) begin
            // Back to IDLE at mid-stop so a following start edge is caught.
            baud_cnt_r <= {CNT_W{1'b0}};
            state_r    <= IDLE;
            if (!rx_s) begin
              frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
              parity_err <= parity_bad_r;
            end else if (parity_bad_r) begin
              parity_err <= 1'b1;
`endif
            end else if (!rx_valid || rx_ready) begin
              rx_data  <= shift_r;
              rx_valid <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + CNT_ONE;
          end
        end

        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// Testbench for uart_rx_core with CLKS_PER_BIT=16. Stimulus pushes the
// expected event (kind, byte, cycle) into a queue; an independent monitor
// pops and compares whenever the DUT delivers a byte or pulses a flag.
module tb_uart_rx_core;

  localparam int CPB = 16;
  localparam int DB  = 8;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 171;
`else
  localparam int LAT = 155;
`endif

  localparam int EV_VALID = 0;
  localparam int EV_FERR  = 1;
  localparam int EV_OVR   = 2;
  localparam int EV_PERR  = 3;
  localparam int EV_NONE  = -1;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic          rx_in    = 1'b1;
  logic          rx_ready = 1'b0;
  logic [DB-1:0] rx_data;
  logic          rx_valid;
  logic          frame_err;
  logic          overrun;
  logic          parity_err;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  typedef struct {
    int         kind;
    logic [7:0] data;
    int         at;
  } ev_t;

  ev_t exp_q[$];

  uart_rx_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_in      (rx_in),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  function automatic string ev_name(input int k);
    case (k)
      EV_VALID: return "valid";
      EV_FERR:  return "frame_err";
      EV_OVR:   return "overrun";
      EV_PERR:  return "parity_err";
      default:  return "none";
    endcase
  endfunction

  task automatic observe(input int kind, input logic [7:0] data);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL unexpected_event: got %s data=%h at cycle %0d, required no event",
               ev_name(kind), data, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.at != cyc || (kind == EV_VALID && e.data !== data)) begin
        fails++;
        $display("FAIL event: got %s data=%h cycle %0d, required %s data=%h cycle %0d",
                 ev_name(kind), data, cyc, ev_name(e.kind), e.data, e.at);
      end
    end
  endtask

  task automatic check_eq(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Monitor: detect byte loads and flag pulses, compare against the queue.
  logic prev_valid = 1'b0;
  logic prev_ready = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid <= 1'b0;
      prev_ready <= 1'b0;
    end else begin
      if (rx_valid && (!prev_valid || prev_ready)) observe(EV_VALID, rx_data);
      if (frame_err)  observe(EV_FERR, 8'h00);
      if (overrun)    observe(EV_OVR, 8'h00);
      if (parity_err) observe(EV_PERR, 8'h00);
      prev_valid <= rx_valid;
      prev_ready <= rx_ready;
    end
  end

  // Drive one frame; optionally raise rx_ready exactly for the load edge.
  task automatic send(input logic [7:0] data, input logic stop, input logic bad_par,
                      input logic ack, input int kind);
    int         start;
    int         nb;
    logic [10:0] bits;
    ev_t        e;
    @(posedge clk); #1;
    start = cyc;
    if (kind != EV_NONE) begin
      e.kind = kind;
      e.data = data;
      e.at   = start + LAT;
      exp_q.push_back(e);
    end
    bits      = 11'h7FF;
    bits[0]   = 1'b0;
    bits[8:1] = data;
`ifdef UART_RX_PARITY_EN
    nb      = 11;
    bits[9]  = (^data) ^ bad_par;
    bits[10] = stop;
`else
    nb      = 10;
    bits[9] = stop;
`endif
    for (int b = 0; b < nb; b++) begin
      rx_in = bits[b];
      for (int i = 0; i < CPB; i++) begin
        @(posedge clk); #1;
        if (ack) rx_ready = (cyc == start + LAT - 1);
      end
    end
  endtask

  task automatic pulse_ready();
    rx_ready = 1'b1;
    @(posedge clk); #1;
    rx_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    repeat (3) @(posedge clk); #1;
    check_eq("reset_rx_valid",   {7'd0, rx_valid},   8'h00);
    check_eq("reset_rx_data",    rx_data,            8'h00);
    check_eq("reset_frame_err",  {7'd0, frame_err},  8'h00);
    check_eq("reset_overrun",    {7'd0, overrun},    8'h00);
    check_eq("reset_parity_err", {7'd0, parity_err}, 8'h00);
    rst_n = 1'b1;
    repeat (5) @(posedge clk); #1;

    // Good frame, consumer stalled; valid holds until rx_ready pulses.
    send(8'h55, 1'b1, 1'b0, 1'b0, EV_VALID);
    repeat (10) @(posedge clk); #1;
    check_eq("hold_valid_55", {7'd0, rx_valid}, 8'h01);
    check_eq("hold_data_55",  rx_data,          8'h55);
    pulse_ready();
    check_eq("clear_valid_55", {7'd0, rx_valid}, 8'h00);

    // False start: 4-cycle low glitch, then a real frame.
    rx_in = 1'b0;
    repeat (4) @(posedge clk); #1;
    rx_in = 1'b1;
    repeat (20) @(posedge clk); #1;
    check_eq("false_start_valid", {7'd0, rx_valid}, 8'h00);
    send(8'hA5, 1'b1, 1'b0, 1'b0, EV_VALID);
    pulse_ready();

    // Framing error, then line held low: no retrigger until a new edge.
    send(8'hA3, 1'b0, 1'b0, 1'b0, EV_FERR);
    repeat (64) @(posedge clk); #1;
    check_eq("ferr_no_valid", {7'd0, rx_valid}, 8'h00);
    rx_in = 1'b1;
    repeat (16) @(posedge clk); #1;
    send(8'h5A, 1'b1, 1'b0, 1'b0, EV_VALID);
    pulse_ready();

    // Back-to-back with consumer stalled: second byte dropped.
    send(8'h12, 1'b1, 1'b0, 1'b0, EV_VALID);
    send(8'h34, 1'b1, 1'b0, 1'b0, EV_OVR);
    check_eq("overrun_keeps_data",  rx_data,          8'h12);
    check_eq("overrun_keeps_valid", {7'd0, rx_valid}, 8'h01);
    pulse_ready();
    check_eq("overrun_clear", {7'd0, rx_valid}, 8'h00);

    // Back-to-back with accept on the load edge: no overrun, new byte loads.
    send(8'h12, 1'b1, 1'b0, 1'b0, EV_VALID);
    send(8'h34, 1'b1, 1'b0, 1'b1, EV_VALID);
    check_eq("accept_load_data",  rx_data,          8'h34);
    check_eq("accept_load_valid", {7'd0, rx_valid}, 8'h01);

    // Reset during data bit 3 of 0x3C.
    d = 8'h3C;
    rx_in = 1'b0;
    repeat (CPB) @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      rx_in = d[k];
      repeat (CPB) @(posedge clk); #1;
    end
    rx_in = d[3];
    repeat (6) @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_eq("midreset_valid",     {7'd0, rx_valid},   8'h00);
    check_eq("midreset_data",      rx_data,            8'h00);
    check_eq("midreset_frame_err", {7'd0, frame_err},  8'h00);
    check_eq("midreset_overrun",   {7'd0, overrun},    8'h00);
    rx_in = 1'b1;
    repeat (3) @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk); #1;
    send(8'hC3, 1'b1, 1'b0, 1'b0, EV_VALID);
    check_eq("after_reset_data", rx_data, 8'hC3);
    pulse_ready();

`ifdef UART_RX_PARITY_EN
    // Wrong parity: byte discarded with parity_err; correct parity delivers.
    send(8'h07, 1'b1, 1'b1, 1'b0, EV_PERR);
    check_eq("perr_no_valid", {7'd0, rx_valid}, 8'h00);
    send(8'h07, 1'b1, 1'b0, 1'b0, EV_VALID);
    check_eq("parity_ok_data", rx_data, 8'h07);
    pulse_ready();
`endif

    repeat (20) @(posedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL pending_events: got %0d events never observed, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Serial-to-parallel receive engine of the UART receiver path. It consumes the single-bit line selected by the loopback 2:1 mux: external RX pin or internal TX loopback. It recovers 8N1 frames using a fixed clocks-per-bit divider and presents each byte on a valid/ready interface to the downstream RX FIFO. It flags framing errors and overruns.

## Interface
- CLKS_PER_BIT, default 868, clocks per bit period (100 MHz / 115200); legal range ≥ 4, even values only.
- DATA_BITS, default 8, data bits per frame; legal range 5–8.
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  asynchronous active-low reset; deassertion is synchronised externally.
- rx_in  input  1  serial line from the loopback mux output; asynchronous to clk; idle level is high.
- rx_data  output  DATA_BITS  received byte, LSB is the first bit on the line; reset value 0.
- rx_valid  output  1  rx_data holds an unconsumed byte; reset value 0.
- rx_ready  input  1  consumer accepts the byte when rx_valid && rx_ready.
- frame_err  output  1  one-cycle pulse when the stop bit is sampled low; reset value 0.
- overrun  output  1  one-cycle pulse when a completed byte is dropped; reset value 0.
- parity_err  output  1  one-cycle pulse on a parity mismatch; reset value 0; tied 0 without the macro.

## Operation
- Input conditioning: rx_in passes through a 2-FF synchroniser whose flops reset to 1. The result is rx_s. rx_prev holds the previous rx_s and also resets to 1.
- State machine: IDLE, START, DATA, PARITY (only with the macro), STOP. Reset state is IDLE.
- IDLE → START when rx_prev=1 and rx_s=0, i.e. a falling edge. The bit counter clears to 0.
  - A line held low after a break does not retrigger; it needs a high-to-low edge.
- START: after CLKS_PER_BIT/2 − 1 further cycles, sample rx_s.
  - If rx_s=1, the start was false: go to IDLE with no flags.
  - Otherwise go to DATA with the counter reset.
- DATA: sample rx_s every CLKS_PER_BIT cycles, at mid-bit. Shift into the shift register LSB-first. After DATA_BITS samples, go to STOP (or PARITY when the macro is defined).
- STOP: sample rx_s at mid-bit.
  - If rx_s=1: deliver the byte, go to IDLE.
  - If rx_s=0: pulse frame_err, discard the byte, go to IDLE.
- Delivery rules:
  - If rx_valid=0, or rx_valid && rx_ready in the same cycle: load rx_data and set rx_valid=1.
  - If rx_valid=1 and rx_ready=0: keep the old rx_data, drop the new byte, pulse overrun.
- Handshake: rx_valid clears on the cycle after rx_valid && rx_ready unless a new byte loads on that same edge. rx_data is stable while rx_valid=1.
- Counters:
  - The baud counter is $clog2(CLKS_PER_BIT) bits wide and wraps to 0 on each sample.
  - The bit counter is $clog2(DATA_BITS+1) bits wide.
- Reset mid-frame: all state returns to reset values immediately; the partial frame is lost. After reset the receiver waits for a fresh falling edge.

## Timing
- Sample points are measured from the cycle rx_s first reads 0, cycle 0:
  - Start sample at cycle CLKS_PER_BIT/2.
  - Data bit k sampled at cycle CLKS_PER_BIT/2 + (k+1)·CLKS_PER_BIT.
- Latency: rx_valid, frame_err and overrun are registered. They assert one cycle after the stop sample, at cycle CLKS_PER_BIT/2 + (DATA_BITS+1)·CLKS_PER_BIT + 1 from rx_s going low.
  - Add 2 cycles of synchroniser delay when measuring from rx_in.
  - With parity, add CLKS_PER_BIT.
- Back-to-back frames: the block returns to IDLE at mid-stop bit, so a start edge at the nominal stop end is caught. Tolerated baud mismatch is ±4% at the defaults.

## Configuration
- UART_RX_PARITY_EN
  - Defined: an even-parity bit follows the data, and PARITY is an active state. Mismatch behaviour:
    - parity_err pulses on the same cycle delivery would have occurred.
    - The byte is discarded.
    - The FSM still checks the stop bit; frame_err has priority and both may pulse together.
  - Undefined: PARITY and its logic are absent, parity_err is constant 0, and the frame is 8N1.

## Structure
- Package uart_pkg holds:
  - the state enum uart_rx_state_t;
  - default constants UART_CLKS_PER_BIT=868 and UART_DATA_BITS=8, shared with the TX path.
- Sub-module uart_rx_sync: 2-FF synchroniser plus falling-edge detect, with outputs rx_s and fall. It is instantiated once.

## Test plan
- All scenarios use CLKS_PER_BIT=16.
- Frame 0x55 with good stop, rx_ready=0 → rx_data=0x55 and rx_valid=1 at cycle 8+9·16+1=153 after rx_s falls. rx_valid holds until rx_ready pulses, then clears next cycle.
- rx_in low for 4 cycles then high → no rx_valid, no frame_err, FSM back in IDLE; a following 0xA5 frame is received correctly.
- Byte 0xA3 with stop bit driven 0 → frame_err one-cycle pulse, rx_valid stays 0; line held low afterwards gives no further activity until rx_in rises and falls again.
- Frames 0x12 then 0x34 back-to-back, rx_ready=0 → rx_data stays 0x12 and overrun pulses once. Repeat with rx_ready=1 on the second load cycle → rx_data=0x34, rx_valid stays 1, no overrun.
- rst_n asserted during data bit 3 of 0x3C → all outputs 0 immediately; next frame 0xC3 is received exactly.
- With UART_RX_PARITY_EN: 0x07 with parity bit 0 → parity_err pulse, no rx_valid; 0x07 with parity bit 1 → rx_data=0x07, rx_valid=1.
